// File: rtl/adc_stream_capture_if.sv
// Per-channel AXI-stream bundle between the capture engine and its consumers.
interface adc_stream_capture_if #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned AXIS_WIDTH = 16
);
    logic [NUM_CH-1:0]            tvalid;
    logic [NUM_CH*AXIS_WIDTH-1:0] tdata;
    logic [NUM_CH-1:0]            tlast;
    logic [NUM_CH-1:0]            tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/adc_stream_capture.sv
// ADC capture engine: formats each channel's sample with its overrange flag,
// buffers it in a per-channel FWFT FIFO and streams it out. Supports continuous
// capture and armed fixed-length bursts terminated with tlast.
module adc_stream_capture #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned AXIS_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                           m_axis_aclk,
    input  logic                           reset,
    input  logic                           adc_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   adc_data,
    input  logic [NUM_CH-1:0]              adc_or,
    input  logic [NUM_CH-1:0]              ctrl_enable,
    input  logic                           ctrl_mode,
    input  logic                           ctrl_arm,
    input  logic                           ctrl_stop,
    input  logic [CNT_WIDTH-1:0]           ctrl_burst_len,
    input  logic                           ctrl_clear,
    adc_stream_capture_if.master           m_axis,
    output logic                           stat_busy,
    output logic [NUM_CH-1:0]              stat_or_sticky,
    output logic [NUM_CH*CNT_WIDTH-1:0]    stat_drop_cnt
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = AXIS_WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BURST} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_WIDTH-1:0] r_burst_len;
    logic [CNT_WIDTH-1:0] r_burst_cnt;
    logic                 w_capture;
    logic                 w_last;
    logic                 w_arm_burst;

    logic                  w_tvalid [NUM_CH];
    logic                  w_tlast  [NUM_CH];
    logic [AXIS_WIDTH-1:0] w_tdata  [NUM_CH];
    logic                  r_sticky [NUM_CH];
    logic [CNT_WIDTH-1:0]  r_drop   [NUM_CH];

    assign w_capture   = adc_valid && (r_state != S_IDLE);
    assign w_last      = (r_state == S_BURST) && (r_burst_cnt == r_burst_len - CNT_WIDTH'(1));
    assign w_arm_burst = (r_state == S_IDLE) && ctrl_arm && ctrl_mode && (ctrl_burst_len != '0);
    assign stat_busy   = (r_state != S_IDLE);

    // State register
    always_ff @(posedge m_axis_aclk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a capture coinciding with stop is still written
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (ctrl_arm && !ctrl_mode)  w_next = S_RUN;
                else if (w_arm_burst)        w_next = S_BURST;
            end
            S_RUN: begin
                if (ctrl_stop) w_next = S_IDLE;
            end
            S_BURST: begin
                if (ctrl_stop || (adc_valid && w_last)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Burst length latch and sample-set counter
    always_ff @(posedge m_axis_aclk) begin
        if (reset) begin
            r_burst_len <= '0;
            r_burst_cnt <= '0;
        end else if (w_arm_burst) begin
            r_burst_len <= ctrl_burst_len;
            r_burst_cnt <= '0;
        end else if (w_capture && (r_state == S_BURST)) begin
            r_burst_cnt <= r_burst_cnt + CNT_WIDTH'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [AXIS_WIDTH:0]          r_mem [FIFO_DEPTH];
            logic [AW:0]                  r_wr;
            logic [AW:0]                  r_rd;
            logic                         w_empty;
            logic                         w_full;
            logic                         w_pop;
            logic                         w_push;
            logic                         w_drop;
            logic signed [DATA_WIDTH-1:0] w_sample;
            logic [AXIS_WIDTH:0]          w_word;
            logic [AXIS_WIDTH:0]          w_head;

            assign w_sample = adc_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_word   = {w_last, adc_or[gi], EW'(w_sample)};
            assign w_empty  = (r_wr == r_rd);
            assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
            assign w_pop    = !w_empty && m_axis.tready[gi];
            assign w_push   = w_capture && ctrl_enable[gi] && (!w_full || w_pop);
            assign w_drop   = w_capture && ctrl_enable[gi] && w_full && !w_pop;
            assign w_head   = r_mem[r_rd[AW-1:0]];

            assign w_tvalid[gi] = !w_empty;
            assign w_tdata[gi]  = w_empty ? '0 : w_head[AXIS_WIDTH-1:0];
            assign w_tlast[gi]  = !w_empty && w_head[AXIS_WIDTH];

            // FIFO storage write
            always_ff @(posedge m_axis_aclk) begin
                if (w_push) r_mem[r_wr[AW-1:0]] <= w_word;
            end

            // FIFO pointers; reset flushes any queued words
            always_ff @(posedge m_axis_aclk) begin
                if (reset) begin
                    r_wr <= '0;
                    r_rd <= '0;
                end else begin
                    if (w_push) r_wr <= r_wr + (AW+1)'(1);
                    if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
                end
            end

            // Sticky overrange; a new overrange beats a simultaneous clear
            always_ff @(posedge m_axis_aclk) begin
                if (reset)                         r_sticky[gi] <= 1'b0;
                else if (adc_valid && adc_or[gi])  r_sticky[gi] <= 1'b1;
                else if (ctrl_clear)               r_sticky[gi] <= 1'b0;
            end

            // Saturating drop counter; a drop coinciding with clear reads as 1
            always_ff @(posedge m_axis_aclk) begin
                if (reset)                         r_drop[gi] <= '0;
                else if (ctrl_clear)               r_drop[gi] <= w_drop ? CNT_WIDTH'(1) : '0;
                else if (w_drop && (r_drop[gi] != '1))
                                                   r_drop[gi] <= r_drop[gi] + CNT_WIDTH'(1);
            end
        end
    endgenerate

    // Pack per-channel results onto the flat output buses
    always_comb begin
        m_axis.tvalid  = '0;
        m_axis.tdata   = '0;
        m_axis.tlast   = '0;
        stat_or_sticky = '0;
        stat_drop_cnt  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            m_axis.tvalid[i]                           = w_tvalid[i];
            m_axis.tdata[i*AXIS_WIDTH +: AXIS_WIDTH]   = w_tdata[i];
            m_axis.tlast[i]                            = w_tlast[i];
            stat_or_sticky[i]                          = r_sticky[i];
            stat_drop_cnt[i*CNT_WIDTH +: CNT_WIDTH]    = r_drop[i];
        end
    end
endmodule

// File: doc/adc_stream_capture.md
# adc_stream_capture

Parametrised N-channel capture engine between the AD9643 LVDS deserialiser output and the per-channel AXI-stream masters. It formats each channel's sample with its overrange flag, buffers it in a per-channel FIFO, and emits it on an independent AXI-stream port. It supports continuous capture and armed fixed-length bursts terminated with tlast, and exposes sticky overrange flags and saturating drop counters for the AXI-lite register bank.

## Interface
- NUM_CH, 2, number of ADC channels (1..8).
- DATA_WIDTH, 14, ADC sample width, two's complement.
- AXIS_WIDTH, 16, stream word width; must be >= DATA_WIDTH+1.
- FIFO_DEPTH, 16, entries per channel FIFO; power of two, >= 4.
- CNT_WIDTH, 16, width of the burst length and drop counters.

- m_axis_aclk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- adc_valid  in  1  one sample set present on adc_data/adc_or this cycle.
- adc_data  in  NUM_CH*DATA_WIDTH  samples; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- adc_or  in  NUM_CH  overrange flags, aligned with adc_data.
- ctrl_enable  in  NUM_CH  per-channel capture enable.
- ctrl_mode  in  1  0 = continuous, 1 = burst; sampled only on ctrl_arm.
- ctrl_arm  in  1  single-cycle start pulse.
- ctrl_stop  in  1  single-cycle abort/stop pulse.
- ctrl_burst_len  in  CNT_WIDTH  sample sets per burst; sampled on ctrl_arm.
- ctrl_clear  in  1  clears stat_or_sticky and stat_drop_cnt.
- m_axis_tvalid  out  NUM_CH  per-channel valid.
- m_axis_tdata  out  NUM_CH*AXIS_WIDTH  per-channel word.
- m_axis_tlast  out  NUM_CH  per-channel end of burst.
- m_axis_tready  in  NUM_CH  per-channel ready.
- stat_busy  out  1  high in RUN or BURST.
- stat_or_sticky  out  NUM_CH  sticky overrange per channel.
- stat_drop_cnt  out  NUM_CH*CNT_WIDTH  saturating dropped-sample counters.

## Operation
- States: IDLE, RUN, BURST.
- IDLE: ctrl_arm with ctrl_mode=0 -> RUN; ctrl_arm with ctrl_mode=1 and ctrl_burst_len != 0 -> BURST, latch length, clear burst counter; ctrl_arm with ctrl_burst_len = 0 is ignored.
- RUN: every adc_valid is a capture; ctrl_stop -> IDLE; tlast is never set.
- BURST: each adc_valid increments the burst counter; the capture where counter == len-1 is written with tlast=1 and the FSM returns to IDLE next cycle. ctrl_stop -> IDLE with no tlast.
- ctrl_arm outside IDLE is ignored. ctrl_stop and a capture in the same cycle: the capture is written, then the FSM goes to IDLE.
- Capture per channel i, only if ctrl_enable[i]: word = {adc_or[i], sign-extended sample to AXIS_WIDTH-1 bits}, plus tlast bit, pushed into FIFO i.
- Disabled channels take no data, but still count toward the burst length.
- FIFO full at capture and no pop in the same cycle: the sample is dropped and stat_drop_cnt[i] increments, saturating at all-ones. A dropped final burst sample loses its tlast. Full with a simultaneous pop: the write is accepted.
- stat_or_sticky[i] sets on any adc_valid with adc_or[i]=1, regardless of state or enable.
- ctrl_clear zeroes stickies and counters. If a clear and a set or increment occur in the same cycle, the event wins: the sticky reads 1 and the counter reads 1.
- FIFOs keep draining in IDLE. Words already queued are never discarded except on reset.

## Timing
- Reset: state IDLE, FIFOs empty; all outputs 0 (tvalid, tdata, tlast, stat_busy, stickies, counters).
- Latency: a capture at edge N is presented on tvalid/tdata at edge N+1 (first-word fall-through).
- AXI-stream: a transfer occurs when tvalid && tready. tdata and tlast hold stable while tvalid && !tready. tvalid never drops without a transfer.
- Sustained throughput is one word per cycle per channel, independent across channels.
- stat_busy rises the cycle after ctrl_arm and falls the cycle after the final burst capture or ctrl_stop.
- Reset mid-burst: FIFOs flush, tvalid drops the next cycle, and no tlast is emitted.

## Test plan
- Continuous mode, tready=1, adc_data ramp 0..31 on both channels: each channel outputs 32 words with tdata equal to the sample, tlast=0, and drop counters at 0.
- Burst with len=8 and adc_valid every cycle: exactly 8 words per channel, tlast only on the 8th, stat_busy high for 8 cycles, and a second ctrl_arm issued mid-burst is ignored.
- Sample 14'h2000 with adc_or=1: tdata=16'hE000 (OR bit set, sign-extended) and stat_or_sticky=1; after ctrl_clear it returns to 0, and a clear coinciding with a new overrange leaves it at 1.
- tready=0 in continuous mode with 20 captures and FIFO_DEPTH=16: 16 words are retained and drop_cnt=4. Then raise tready: the 16 words emerge in order with no gaps.
- Channel A tready toggling 1/0 and channel B tready=1: B stays cycle-accurate, and A's data is stable during stalls and complete.
- Assert reset at burst sample 3 of 8: outputs are 0 the next cycle, and a new burst after reset delivers 8 fresh words.
